// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit_pkg
// Description : Shared constants for the instruction-fetch stage: exception
//               codes, reset vector, stall-vector bit indices and the fetch
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

    // Boot ROM entry point
    localparam logic [31:0] c_reset_pc   = 32'hBFC00000;

    // Exception codes carried in exr_type
    localparam logic [5:0]  c_exr_int    = 6'h00;
    localparam logic [5:0]  c_exr_adel   = 6'h04;
    localparam logic [5:0]  c_exr_ades   = 6'h05;
    localparam logic [5:0]  c_exr_sys    = 6'h08;
    localparam logic [5:0]  c_exr_bp     = 6'h09;
    localparam logic [5:0]  c_exr_ri     = 6'h0a;
    localparam logic [5:0]  c_exr_ov     = 6'h0c;
    localparam logic [5:0]  c_exr_eret   = 6'h0e;

    // Bit positions inside the shared stall vector
    localparam int          c_stall_if   = 0;
    localparam int          c_stall_id   = 1;
    localparam int          c_stall_ex   = 2;
    localparam int          c_stall_mem  = 3;
    localparam int          c_stall_wb   = 4;

    // Fetch state encoding
    localparam int                    c_state_w    = 2;
    localparam logic [c_state_w-1:0]  c_st_req     = 2'd0;
    localparam logic [c_state_w-1:0]  c_st_wait    = 2'd1;
    localparam logic [c_state_w-1:0]  c_st_hold    = 2'd2;
    localparam logic [c_state_w-1:0]  c_st_discard = 2'd3;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_inst_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit_inst_buffer
// Description : Single-entry buffer holding the fetched instruction and its
//               fetch-exception fields until the IF/ID register consumes it.
//               Clear wins over load. While empty, every field reads as zero
//               so the outputs double as a bubble.
// Ports       : clock, reset        - clock / asynchronous active-high reset
//               i_load, i_clear     - capture new entry / empty the buffer
//               i_addr..i_exr_a0    - entry to capture
//               o_valid..o_exr_a0   - current buffer contents
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit_inst_buffer (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_inst,
    input  logic        i_exr_valid,
    input  logic [5:0]  i_exr_type,
    input  logic [31:0] i_exr_a0,
    output logic        o_valid,
    output logic [31:0] o_addr,
    output logic [31:0] o_inst,
    output logic        o_exr_valid,
    output logic [5:0]  o_exr_type,
    output logic [31:0] o_exr_a0
);

    logic        r_valid;
    logic [31:0] r_addr;
    logic [31:0] r_inst;
    logic        r_exr_valid;
    logic [5:0]  r_exr_type;
    logic [31:0] r_exr_a0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_inst      <= '0;
            r_exr_valid <= 1'b0;
            r_exr_type  <= '0;
            r_exr_a0    <= '0;
        end else if (i_clear) begin
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_inst      <= '0;
            r_exr_valid <= 1'b0;
            r_exr_type  <= '0;
            r_exr_a0    <= '0;
        end else if (i_load) begin
            r_valid     <= 1'b1;
            r_addr      <= i_addr;
            r_inst      <= i_inst;
            r_exr_valid <= i_exr_valid;
            r_exr_type  <= i_exr_type;
            r_exr_a0    <= i_exr_a0;
        end
    end

    assign o_valid     = r_valid;
    assign o_addr      = r_addr;
    assign o_inst      = r_inst;
    assign o_exr_valid = r_exr_valid;
    assign o_exr_type  = r_exr_type;
    assign o_exr_a0    = r_exr_a0;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage. Owns the PC, issues one outstanding
//               read on the req/addr_ok/data_ok instruction bus, buffers the
//               returned word and presents it to the IF/ID register under the
//               shared stall vector. Handles delay-slot branch redirects,
//               exception flushes and misaligned-PC AdEL without bus access.
// Ports       : clock, reset            - clock / async active-high reset
//               stall[4:0]              - stall vector, bit0 holds IF
//               branch_valid/_target    - taken branch resolved in ID
//               flush/flush_target      - exception or eret redirect
//               inst_req/addr/addr_ok/data_ok/rdata - instruction bus
//               out_addr/inst/exr_*     - buffered instruction to IF/ID
//               fetch_stall_req         - no valid instruction buffered
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter logic [5:0]  EXR_ADEL = c_exr_adel
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] out_addr,
    output logic [31:0] out_inst,
    output logic        out_exr_valid,
    output logic [5:0]  out_exr_type,
    output logic [31:0] out_exr_a0,
    output logic        fetch_stall_req
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic [31:0]          r_pc;
    logic [31:0]          w_pc_nxt;
    logic                 r_pend_valid;
    logic                 w_pend_valid_nxt;
    logic [31:0]          r_pend_target;
    logic [31:0]          w_pend_target_nxt;

    logic                 w_req;
    logic                 w_load;
    logic                 w_clear;
    logic [31:0]          w_load_inst;
    logic                 w_load_exr;
    logic                 w_buf_valid;
    logic                 w_misaligned;
    logic                 w_unused_stall;

    assign w_misaligned   = |r_pc[1:0];
    // Only the IF bit of the stall vector matters to this stage
    assign w_unused_stall = ^stall[c_stall_wb:c_stall_id];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_req;
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        w_req             = 1'b0;
        w_load            = 1'b0;
        w_clear           = 1'b0;
        w_load_inst       = '0;
        w_load_exr        = 1'b0;

        // The fetch in flight is the delay slot; the redirect waits for it
        if (branch_valid) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_target_nxt = branch_target;
        end

        case (r_state)
            c_st_req: begin
                if (w_misaligned) begin
                    w_load      = 1'b1;
                    w_load_exr  = 1'b1;
                    w_state_nxt = c_st_hold;
                end else begin
                    w_req = 1'b1;
                    if (inst_addr_ok) begin
                        w_state_nxt = c_st_wait;
                    end
                end
            end
            c_st_wait: begin
                if (inst_data_ok) begin
                    w_load      = 1'b1;
                    w_load_inst = inst_rdata;
                    w_state_nxt = c_st_hold;
                end
            end
            c_st_hold: begin
                if (!stall[c_stall_if]) begin
                    w_clear          = 1'b1;
                    w_pend_valid_nxt = 1'b0;
                    // A branch resolving in the consume cycle redirects at once
                    if (branch_valid) begin
                        w_pc_nxt = branch_target;
                    end else if (r_pend_valid) begin
                        w_pc_nxt = r_pend_target;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                    w_state_nxt = c_st_req;
                end
            end
            c_st_discard: begin
                if (inst_data_ok) begin
                    w_state_nxt = c_st_req;
                end
            end
            default: begin
                w_state_nxt = c_st_req;
            end
        endcase

        // Flush overrides everything. A read still owed by the bus must be
        // drained in DISCARD; if its data arrives this very cycle it is
        // simply dropped and fetching restarts immediately.
        if (flush) begin
            w_pc_nxt         = flush_target;
            w_pend_valid_nxt = 1'b0;
            w_clear          = 1'b1;
            w_load           = 1'b0;
            if ((r_state == c_st_req && w_req && inst_addr_ok) ||
                ((r_state == c_st_wait || r_state == c_st_discard) && !inst_data_ok)) begin
                w_state_nxt = c_st_discard;
            end else begin
                w_state_nxt = c_st_req;
            end
        end
    end

    if_fetch_unit_inst_buffer u_inst_buffer (
        .clock       (clock),
        .reset       (reset),
        .i_load      (w_load),
        .i_clear     (w_clear),
        .i_addr      (r_pc),
        .i_inst      (w_load_inst),
        .i_exr_valid (w_load_exr),
        .i_exr_type  (w_load_exr ? EXR_ADEL : 6'h00),
        .i_exr_a0    (w_load_exr ? r_pc : 32'h0),
        .o_valid     (w_buf_valid),
        .o_addr      (out_addr),
        .o_inst      (out_inst),
        .o_exr_valid (out_exr_valid),
        .o_exr_type  (out_exr_type),
        .o_exr_a0    (out_exr_a0)
    );

    // State resets to REQ, so the request is masked while reset is held
    assign inst_req        = w_req & ~reset;
    assign inst_addr       = r_pc;
    assign fetch_stall_req = ~w_buf_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Scoreboard bench for if_fetch_unit. Stimulus pushes expected
//               bus addresses and IF/ID deliveries; a negedge monitor pops and
//               compares them whenever the DUT issues an accepted request or
//               hands an instruction to IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam int ADDR_LAT = 1;
    localparam int DATA_LAT = 2;

    logic        clock;
    logic        reset;
    logic [4:0]  stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] out_addr;
    logic [31:0] out_inst;
    logic        out_exr_valid;
    logic [5:0]  out_exr_type;
    logic [31:0] out_exr_a0;
    logic        fetch_stall_req;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        ev;
        logic [5:0]  et;
        logic [31:0] a0;
    } deliv_t;

    logic [31:0] exp_req[$];
    deliv_t      exp_del[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    if_fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .branch_valid    (branch_valid),
        .branch_target   (branch_target),
        .flush           (flush),
        .flush_target    (flush_target),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .out_addr        (out_addr),
        .out_inst        (out_inst),
        .out_exr_valid   (out_exr_valid),
        .out_exr_type    (out_exr_type),
        .out_exr_a0      (out_exr_a0),
        .fetch_stall_req (fetch_stall_req)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push_del(input logic [31:0] a, input logic [31:0] i,
                            input logic ev, input logic [5:0] et, input logic [31:0] a0);
        deliv_t d;
        d.addr = a; d.inst = i; d.ev = ev; d.et = et; d.a0 = a0;
        exp_del.push_back(d);
    endtask

    task automatic wait_accept(input logic [31:0] a);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!(inst_addr_ok && inst_addr == a) && n < 40);
        chk("accept_timeout", {63'd0, inst_addr_ok && inst_addr == a}, 64'd1);
    endtask

    task automatic wait_full();
        int n = 0;
        while (fetch_stall_req && n < 40) begin
            cyc();
            n++;
        end
        chk("full_timeout", {63'd0, fetch_stall_req}, 64'd0);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'hBFC00000: return 32'h24020001;
            32'hBFC00004: return 32'h24030002;
            32'hBFC00100: return 32'h8C040010;
            32'hBFC00380: return 32'h42000018;
            default:      return ~a;
        endcase
    endfunction

    // Bus slave: ADDR_LAT idle request cycles before addr_ok, data_ok
    // DATA_LAT cycles after addr_ok; never both in the same cycle.
    logic [31:0] s_addr;
    int          s_cnt;
    int          s_acnt;
    logic        s_busy;
    initial begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        s_busy       = 1'b0;
        s_cnt        = 0;
        s_acnt       = ADDR_LAT;
        s_addr       = '0;
        forever begin
            @(posedge clock);
            #2;
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            if (reset) begin
                s_busy = 1'b0;
                s_acnt = ADDR_LAT;
            end else if (s_busy) begin
                if (s_cnt == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = mem_word(s_addr);
                    s_busy       = 1'b0;
                end else begin
                    s_cnt--;
                end
            end else if (inst_req) begin
                if (s_acnt == 0) begin
                    inst_addr_ok = 1'b1;
                    s_busy       = 1'b1;
                    s_addr       = inst_addr;
                    s_cnt        = DATA_LAT - 1;
                    s_acnt       = ADDR_LAT;
                end else begin
                    s_acnt--;
                end
            end
        end
    end

    // Monitor
    deliv_t      mon_e;
    logic [31:0] mon_a;
    always @(negedge clock) begin
        if (!reset) begin
            if (inst_req && inst_addr_ok) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_req", {32'd0, inst_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_a = exp_req.pop_front();
                    chk("req_addr", {32'd0, inst_addr}, {32'd0, mon_a});
                end
            end
            if (!fetch_stall_req && !stall[0]) begin
                if (exp_del.size() == 0) begin
                    chk("unexpected_deliv", {32'd0, out_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_e = exp_del.pop_front();
                    chk("deliv_addr", {32'd0, out_addr}, {32'd0, mon_e.addr});
                    chk("deliv_inst", {32'd0, out_inst}, {32'd0, mon_e.inst});
                    chk("deliv_exr", {25'd0, out_exr_valid, out_exr_type, out_exr_a0},
                        {25'd0, mon_e.ev, mon_e.et, mon_e.a0});
                end
            end
            if (fetch_stall_req) begin
                chk("bubble", {31'd0, out_exr_valid, out_inst}, 64'd0);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        stall         = 5'b00011;
        branch_valid  = 1'b0;
        branch_target = '0;
        flush         = 1'b0;
        flush_target  = '0;
        #1;
        chk("rst_req", {63'd0, inst_req}, 64'd0);
        chk("rst_out", {out_addr, out_inst}, 64'd0);
        chk("rst_exr", {25'd0, out_exr_valid, out_exr_type, out_exr_a0}, 64'd0);
        chk("rst_stall_req", {63'd0, fetch_stall_req}, 64'd1);
        cyc();
        cyc();
        reset = 1'b0;

        // First fetch, held under stall for three cycles
        exp_req.push_back(32'hBFC00000);
        wait_full();
        for (int i = 0; i < 3; i++) begin
            chk("hold_addr", {32'd0, out_addr}, 64'hBFC00000);
            chk("hold_inst", {32'd0, out_inst}, 64'h24020001);
            chk("hold_no_req", {63'd0, inst_req}, 64'd0);
            cyc();
        end
        push_del(32'hBFC00000, 32'h24020001, 1'b0, 6'h00, 32'h0);
        exp_req.push_back(32'hBFC00004);
        stall = 5'b00000;

        // Branch while the delay slot is in flight
        wait_accept(32'hBFC00004);
        branch_valid  = 1'b1;
        branch_target = 32'hBFC00100;
        push_del(32'hBFC00004, 32'h24030002, 1'b0, 6'h00, 32'h0);
        exp_req.push_back(32'hBFC00100);
        push_del(32'hBFC00100, 32'h8C040010, 1'b0, 6'h00, 32'h0);
        exp_req.push_back(32'hBFC00104);
        cyc();
        branch_valid = 1'b0;

        // Flush while waiting for data: the returning word is dropped
        wait_accept(32'hBFC00104);
        flush        = 1'b1;
        flush_target = 32'hBFC00380;
        exp_req.push_back(32'hBFC00380);
        push_del(32'hBFC00380, 32'h42000018, 1'b0, 6'h00, 32'h0);
        exp_req.push_back(32'hBFC00384);
        cyc();
        flush = 1'b0;

        // Flush to a misaligned target, with a competing branch
        wait_accept(32'hBFC00384);
        flush         = 1'b1;
        flush_target  = 32'hBFC00382;
        branch_valid  = 1'b1;
        branch_target = 32'h12345678;
        stall         = 5'b00001;
        cyc();
        flush        = 1'b0;
        branch_valid = 1'b0;
        wait_full();
        chk("adel_valid", {63'd0, out_exr_valid}, 64'd1);
        chk("adel_type", {58'd0, out_exr_type}, 64'h04);
        chk("adel_a0", {32'd0, out_exr_a0}, 64'hBFC00382);
        chk("adel_inst", {32'd0, out_inst}, 64'd0);
        chk("adel_no_req", {63'd0, inst_req}, 64'd0);
        push_del(32'hBFC00382, 32'h0, 1'b1, 6'h04, 32'hBFC00382);
        stall = 5'b00000;
        cyc();
        stall = 5'b00001;
        wait_full();
        chk("adel_next_addr", {32'd0, out_addr}, 64'hBFC00386);

        // Flush in HOLD, then fetch across the 2^32 wrap
        flush        = 1'b1;
        flush_target = 32'hFFFFFFFC;
        exp_req.push_back(32'hFFFFFFFC);
        push_del(32'hFFFFFFFC, 32'h00000003, 1'b0, 6'h00, 32'h0);
        exp_req.push_back(32'h00000000);
        cyc();
        flush = 1'b0;
        stall = 5'b00000;
        wait_accept(32'h00000000);

        // Reset while waiting for data
        reset = 1'b1;
        #1;
        chk("mid_rst_req", {63'd0, inst_req}, 64'd0);
        chk("mid_rst_out", {out_addr, out_inst}, 64'd0);
        chk("mid_rst_stall_req", {63'd0, fetch_stall_req}, 64'd1);
        cyc();
        cyc();
        stall = 5'b00001;
        reset = 1'b0;
        exp_req.push_back(32'hBFC00000);
        wait_full();

        // Branch resolving in the consume cycle redirects immediately
        stall         = 5'b00000;
        branch_valid  = 1'b1;
        branch_target = 32'hBFC00200;
        push_del(32'hBFC00000, 32'h24020001, 1'b0, 6'h00, 32'h0);
        exp_req.push_back(32'hBFC00200);
        cyc();
        stall        = 5'b00001;
        branch_valid = 1'b0;
        wait_full();
        chk("direct_br_addr", {32'd0, out_addr}, 64'hBFC00200);
        chk("direct_br_inst", {32'd0, out_inst}, 64'h403FFDFF);
        push_del(32'hBFC00200, 32'h403FFDFF, 1'b0, 6'h00, 32'h0);
        exp_req.push_back(32'hBFC00204);
        stall = 5'b00000;
        cyc();
        stall = 5'b00001;
        repeat (8) cyc();

        chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
        chk("deliv_queue_empty", 64'(exp_del.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
